// File: rtl/svpwm_modulator.sv
// ---------------------------------------------------------------------------
// svpwm_modulator
//   Turns alpha/beta voltage references into three centre-aligned PWM gate
//   signals. The datapath does an inverse Clarke transform and an optional
//   min-max zero-sequence injection, then scales each phase to a carrier
//   compare value. The FSM takes one cycle per stage:
//   IDLE -> CLARKE -> OFFSET -> SCALE -> IDLE.
//   Results sit in shadow registers. They move into the active compare
//   registers only at the carrier valley.
//
//   Optional feature: define SVPWM_MINMAX_EN to enable min-max zero-sequence
//   injection (SVPWM). When it is undefined, the offset is zero (sinusoidal
//   PWM) and the OFFSET stage still takes one cycle.
//
// Ports
//   clk, rstb          clock, asynchronous active-low reset
//   alpha, beta        signed Q(Q_BITS) voltage references, latched on start
//   start              one-cycle request; ignored unless idle
//   pwm_en             gate enable; 0 forces pwm_* low on the next edge
//   busy               FSM not idle
//   done               one-cycle pulse when new compare values are pending
//   update             one-cycle pulse when pending values became active
//   sync               high in the cycle where cnt == 0
//   cnt                triangle carrier count 0..PERIOD..0
//   cmp_a/b/c          active compare values
//   pwm_a/b/c          high-side gate signals, high while cnt < cmp_x
// ---------------------------------------------------------------------------
module svpwm_modulator #(
   parameter int D_WIDTH   = 19,
   parameter int Q_BITS    = 15,
   parameter int CNT_WIDTH = 12,
   parameter int PERIOD    = 2500
) (
   input  logic                      clk,
   input  logic                      rstb,
   input  logic signed [D_WIDTH-1:0] alpha,
   input  logic signed [D_WIDTH-1:0] beta,
   input  logic                      start,
   input  logic                      pwm_en,
   output logic                      busy,
   output logic                      done,
   output logic                      update,
   output logic                      sync,
   output logic [CNT_WIDTH-1:0]      cnt,
   output logic [CNT_WIDTH-1:0]      cmp_a,
   output logic [CNT_WIDTH-1:0]      cmp_b,
   output logic [CNT_WIDTH-1:0]      cmp_c,
   output logic                      pwm_a,
   output logic                      pwm_b,
   output logic                      pwm_c
);

   localparam int VW = D_WIDTH + 2;           // phase voltage width
   localparam int OW = VW + 1;                // offset-injected phase width
   localparam int KW = 16;                    // width of the sqrt(3)/2 constant
   localparam int BW = D_WIDTH + KW;          // beta * k product width
   localparam int PW = OW + CNT_WIDTH + 2;    // phase * PERIOD product width

   localparam logic signed [KW-1:0] K_SQRT3_2 = 16'sd28378;
   localparam logic signed [PW-1:0] PERIOD_X  = PW'(PERIOD);
   localparam logic signed [PW-1:0] HALF_X    = PW'(PERIOD / 2);
   localparam logic [CNT_WIDTH-1:0] CNT_TOP   = CNT_WIDTH'(PERIOD);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = {CNT_WIDTH{1'b0}};

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_CLARKE = 2'd1,
      S_OFFSET = 2'd2,
      S_SCALE  = 2'd3
   } state_t;

   state_t                   state_r, state_s;
   logic                     dir_r, dir_s;           // 1 = counting up
   logic [CNT_WIDTH-1:0]     cnt_s;
   logic signed [D_WIDTH-1:0] alpha_r, beta_r;
   logic signed [VW-1:0]     va_r, vb_r, vc_r;
   logic signed [OW-1:0]     pa_r, pb_r, pc_r;
   logic [CNT_WIDTH-1:0]     pend_a_r, pend_b_r, pend_c_r;
   logic                     pend_flag_r;
   logic signed [VW-1:0]     half_s, beta_t_s, vb_s, vc_s;
   logic signed [BW-1:0]     beta_k_s;
   logic signed [OW-1:0]     off_s, pa_s, pb_s, pc_s;
   logic                     load_s;
   logic [CNT_WIDTH-1:0]     cmp_a_s, cmp_b_s, cmp_c_s;
`ifdef SVPWM_MINMAX_EN
   logic signed [VW-1:0]     mx1_s, mx_s, mn1_s, mn_s;
   logic signed [OW-1:0]     sum_s;
`endif

   // Phase voltage -> carrier compare value, saturated to [0, PERIOD].
   function automatic logic [CNT_WIDTH-1:0] to_compare(input logic signed [OW-1:0] v);
      logic signed [PW-1:0] prod;
      logic signed [PW-1:0] t;
      prod = PW'(v) * PERIOD_X;
      t    = (prod >>> Q_BITS) + HALF_X;
      if (t[PW-1]) begin
         to_compare = CNT_ZERO;
      end else if (t > PERIOD_X) begin
         to_compare = CNT_TOP;
      end else begin
         to_compare = t[CNT_WIDTH-1:0];
      end
   endfunction

   // Carrier next count; direction turns around at PERIOD and at 0.
   always_comb begin
      cnt_s = cnt;
      dir_s = dir_r;
      if (dir_r) begin
         cnt_s = cnt + CNT_ONE;
         dir_s = (cnt != (CNT_TOP - CNT_ONE));
      end else begin
         cnt_s = cnt - CNT_ONE;
         dir_s = (cnt == CNT_ONE);
      end
   end

   // Free-running triangle carrier and valley marker.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         cnt   <= CNT_ZERO;
         dir_r <= 1'b1;
         sync  <= 1'b0;
      end else begin
         cnt   <= cnt_s;
         dir_r <= dir_s;
         sync  <= (cnt_s == CNT_ZERO);
      end
   end

   // FSM next state: start is only accepted in S_IDLE.
   always_comb begin
      state_s = state_r;
      case (state_r)
         S_IDLE:   state_s = start ? S_CLARKE : S_IDLE;
         S_CLARKE: state_s = S_OFFSET;
         S_OFFSET: state_s = S_SCALE;
         S_SCALE:  state_s = S_IDLE;
         default:  state_s = S_IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Registered status flags aligned with the state they describe.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         busy <= (state_s != S_IDLE);
         done <= (state_r == S_SCALE);
      end
   end

   // Inverse Clarke; beta*k keeps full width before the Q shift.
   always_comb begin
      half_s   = VW'(alpha_r) >>> 1;
      beta_k_s = BW'(beta_r) * BW'(K_SQRT3_2);
      beta_t_s = VW'(beta_k_s >>> Q_BITS);
      vb_s     = -half_s + beta_t_s;
      vc_s     = -half_s - beta_t_s;
   end

   // Zero-sequence offset: centre the max/min envelope around zero.
   always_comb begin
`ifdef SVPWM_MINMAX_EN
      mx1_s = (va_r > vb_r) ? va_r : vb_r;
      mx_s  = (mx1_s > vc_r) ? mx1_s : vc_r;
      mn1_s = (va_r < vb_r) ? va_r : vb_r;
      mn_s  = (mn1_s < vc_r) ? mn1_s : vc_r;
      sum_s = OW'(mx_s) + OW'(mn_s);
      off_s = -(sum_s >>> 1);
`else
      off_s = {OW{1'b0}};
`endif
      pa_s = OW'(va_r) + off_s;
      pb_s = OW'(vb_r) + off_s;
      pc_s = OW'(vc_r) + off_s;
   end

   // Datapath pipeline registers, one stage per FSM state.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         alpha_r  <= {D_WIDTH{1'b0}};
         beta_r   <= {D_WIDTH{1'b0}};
         va_r     <= {VW{1'b0}};
         vb_r     <= {VW{1'b0}};
         vc_r     <= {VW{1'b0}};
         pa_r     <= {OW{1'b0}};
         pb_r     <= {OW{1'b0}};
         pc_r     <= {OW{1'b0}};
         pend_a_r <= CNT_ZERO;
         pend_b_r <= CNT_ZERO;
         pend_c_r <= CNT_ZERO;
      end else begin
         if ((state_r == S_IDLE) && start) begin
            alpha_r <= alpha;
            beta_r  <= beta;
         end
         if (state_r == S_CLARKE) begin
            va_r <= VW'(alpha_r);
            vb_r <= vb_s;
            vc_r <= vc_s;
         end
         if (state_r == S_OFFSET) begin
            pa_r <= pa_s;
            pb_r <= pb_s;
            pc_r <= pc_s;
         end
         if (state_r == S_SCALE) begin
            pend_a_r <= to_compare(pa_r);
            pend_b_r <= to_compare(pb_r);
            pend_c_r <= to_compare(pc_r);
         end
      end
   end

   // Valley load selects the shadow values; pwm uses next cnt/cmp so the
   // registered gate matches the count visible in the same cycle.
   always_comb begin
      load_s  = (cnt == CNT_ZERO) && pend_flag_r;
      cmp_a_s = load_s ? pend_a_r : cmp_a;
      cmp_b_s = load_s ? pend_b_r : cmp_b;
      cmp_c_s = load_s ? pend_c_r : cmp_c;
   end

   // Shadow-to-active transfer and gate outputs. A done on the valley edge
   // re-arms the flag after the old pending values have been consumed.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         pend_flag_r <= 1'b0;
         update      <= 1'b0;
         cmp_a       <= CNT_ZERO;
         cmp_b       <= CNT_ZERO;
         cmp_c       <= CNT_ZERO;
         pwm_a       <= 1'b0;
         pwm_b       <= 1'b0;
         pwm_c       <= 1'b0;
      end else begin
         if (state_r == S_SCALE) begin
            pend_flag_r <= 1'b1;
         end else if (load_s) begin
            pend_flag_r <= 1'b0;
         end
         update <= load_s;
         cmp_a  <= cmp_a_s;
         cmp_b  <= cmp_b_s;
         cmp_c  <= cmp_c_s;
         pwm_a  <= pwm_en & (cnt_s < cmp_a_s);
         pwm_b  <= pwm_en & (cnt_s < cmp_b_s);
         pwm_c  <= pwm_en & (cnt_s < cmp_c_s);
      end
   end

endmodule

// File: tb/tb_svpwm_modulator.sv
// ---------------------------------------------------------------------------
// tb_svpwm_modulator
//   Self-checking bench for svpwm_modulator. Expected compare values come from
//   an integer reference of the modulation equations. The expected carrier
//   comes from the cycle count since reset.
// ---------------------------------------------------------------------------
module tb_svpwm_modulator;

   localparam int DW   = 19;
   localparam int CW   = 12;
   localparam int PER  = 2500;
   localparam int CPER = 2 * PER;

   logic                 clk = 1'b0;
   logic                 rstb = 1'b0;
   logic signed [DW-1:0] alpha = '0;
   logic signed [DW-1:0] beta = '0;
   logic                 start = 1'b0;
   logic                 pwm_en = 1'b0;
   logic                 busy, done, update, sync;
   logic [CW-1:0]        cnt, cmp_a, cmp_b, cmp_c;
   logic                 pwm_a, pwm_b, pwm_c;

   int n_cmp = 0;
   int n_bad = 0;
   int t_rst;

   svpwm_modulator dut (
      .clk(clk), .rstb(rstb), .alpha(alpha), .beta(beta), .start(start),
      .pwm_en(pwm_en), .busy(busy), .done(done), .update(update), .sync(sync),
      .cnt(cnt), .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_c(cmp_c),
      .pwm_a(pwm_a), .pwm_b(pwm_b), .pwm_c(pwm_c)
   );

   always #5 clk = ~clk;

   // Clock edges seen since reset release.
   always @(posedge clk or negedge rstb) begin
      if (!rstb) t_rst <= 0;
      else       t_rst <= t_rst + 1;
   end

   // ---------------- reference model ----------------
   function automatic longint fdiv(longint n, longint d);
      longint q;
      q = n / d;
      if ((n % d) != 0 && n < 0) q = q - 1;
      return q;
   endfunction

   function automatic int tri_cnt(int t);
      int m;
      m = t % CPER;
      return (m <= PER) ? m : CPER - m;
   endfunction

   function automatic int to_cmp(longint v);
      longint t;
      t = PER / 2 + fdiv(v * PER, 32768);
      if (t < 0) return 0;
      if (t > PER) return PER;
      return int'(t);
   endfunction

   function automatic void ref_cmp(input int a, input int b,
                                   output int ea, output int eb, output int ec);
      longint va, vb, vc, bk, off;
`ifdef SVPWM_MINMAX_EN
      longint mx, mn;
`endif
      bk = fdiv(longint'(b) * 28378, 32768);
      va = a;
      vb = -fdiv(a, 2) + bk;
      vc = -fdiv(a, 2) - bk;
`ifdef SVPWM_MINMAX_EN
      mx = va; if (vb > mx) mx = vb; if (vc > mx) mx = vc;
      mn = va; if (vb < mn) mn = vb; if (vc < mn) mn = vc;
      off = -fdiv(mx + mn, 2);
`else
      off = 0;
`endif
      ea = to_cmp(va + off);
      eb = to_cmp(vb + off);
      ec = to_cmp(vc + off);
   endfunction

   // ---------------- stimulus utilities (no checking) ----------------
   // Pulse start; returns negedges from assertion until done (-1 on timeout).
   task automatic start_and_time(input int a, input int b, output int lat);
      alpha = DW'(a);
      beta  = DW'(b);
      start = 1'b1;
      lat   = -1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (done) begin
            lat = i;
            break;
         end
      end
   endtask

   // Wait for an update pulse; returns t_rst of that cycle (-1 on timeout).
   task automatic wait_update(output int t_at);
      t_at = -1;
      for (int i = 0; i < 11000; i++) begin
         @(negedge clk);
         if (update) begin
            t_at = t_rst;
            break;
         end
      end
   endtask

   // Advance to the negedge where t_rst % CPER == ph.
   task automatic wait_phase(input int ph, output bit ok);
      ok = 1'b0;
      for (int i = 0; i <= CPER; i++) begin
         @(negedge clk);
         if ((t_rst % CPER) == ph) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rstb = 1'b0;
      pwm_en = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({busy, done, update, sync, pwm_a, pwm_b, pwm_c} !== 7'b0) begin
         n_bad++;
         $display("FAIL reset_flags: got %b expected 0000000", {busy, done, update, sync, pwm_a, pwm_b, pwm_c});
      end
      n_cmp++;
      if ({cnt, cmp_a, cmp_b, cmp_c} !== 48'd0) begin
         n_bad++;
         $display("FAIL reset_values: cnt=%0d cmp=%0d/%0d/%0d expected all 0", cnt, cmp_a, cmp_b, cmp_c);
      end
      rstb = 1'b1;
   endtask

   task automatic test_carrier();
      int c;
      bit es;
      for (int i = 0; i <= CPER; i++) begin
         if (i > 0) @(negedge clk);
         c  = tri_cnt(t_rst);
         es = (t_rst > 0) && (c == 0);
         n_cmp++;
         if (int'(cnt) !== c || sync !== es) begin
            n_bad++;
            $display("FAIL carrier t=%0d: cnt=%0d sync=%b expected cnt=%0d sync=%b", t_rst, cnt, sync, c, es);
         end
         n_cmp++;
         if ({pwm_a, pwm_b, pwm_c} !== 3'b0 || {cmp_a, cmp_b, cmp_c} !== 36'd0) begin
            n_bad++;
            $display("FAIL idle_outputs t=%0d: pwm=%b cmp=%0d/%0d/%0d expected 0", t_rst, {pwm_a, pwm_b, pwm_c}, cmp_a, cmp_b, cmp_c);
         end
      end
   endtask

   // Gate outputs over one full carrier period against the gate rule.
   task automatic test_gate_window(input int ea, input int eb, input int ec, input string tag);
      int c;
      logic [2:0] ep;
      for (int i = 0; i < CPER; i++) begin
         @(negedge clk);
         c  = tri_cnt(t_rst);
         ep = {c < ea, c < eb, c < ec};
         n_cmp++;
         if ({pwm_a, pwm_b, pwm_c} !== ep) begin
            n_bad++;
            $display("FAIL gate_%s cnt=%0d: pwm=%b expected %b", tag, c, {pwm_a, pwm_b, pwm_c}, ep);
         end
      end
   endtask

   // Issue one request and check latency, load phase and compare values.
   task automatic run_case(input int a, input int b, input int ea, input int eb, input int ec, input string tag);
      int lat, tu;
      start_and_time(a, b, lat);
      n_cmp++;
      if (lat != 4) begin
         n_bad++;
         $display("FAIL latency_%s: got %0d expected 4", tag, lat);
      end
      wait_update(tu);
      n_cmp++;
      if (tu < 0 || (tu % CPER) != 1) begin
         n_bad++;
         $display("FAIL update_phase_%s: got t=%0d expected phase 1", tag, tu);
      end
      n_cmp++;
      if (int'(cmp_a) != ea || int'(cmp_b) != eb || int'(cmp_c) != ec) begin
         n_bad++;
         $display("FAIL cmp_%s: got %0d/%0d/%0d expected %0d/%0d/%0d", tag, cmp_a, cmp_b, cmp_c, ea, eb, ec);
      end
   endtask

   task automatic test_zero();
      run_case(0, 0, 1250, 1250, 1250, "zero");
      test_gate_window(1250, 1250, 1250, "zero");
   endtask

   task automatic test_pwm_enable();
      bit ok;
      int c;
      wait_phase(CPER - 100, ok);
      n_cmp++;
      if (!ok || pwm_a !== 1'b1) begin
         n_bad++;
         $display("FAIL en_before: ok=%b pwm_a=%b expected 1", ok, pwm_a);
      end
      pwm_en = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         c = tri_cnt(t_rst);
         n_cmp++;
         if ({pwm_a, pwm_b, pwm_c} !== 3'b0 || int'(cnt) !== c || sync !== (c == 0)) begin
            n_bad++;
            $display("FAIL en_low cnt=%0d: pwm=%b sync=%b expected pwm=000 cnt=%0d sync=%b",
                     cnt, {pwm_a, pwm_b, pwm_c}, sync, c, (c == 0));
         end
      end
      pwm_en = 1'b1;
      @(negedge clk);
      c = tri_cnt(t_rst);
      n_cmp++;
      if (pwm_a !== (c < 1250)) begin
         n_bad++;
         $display("FAIL en_restore cnt=%0d: pwm_a=%b expected %b", c, pwm_a, (c < 1250));
      end
   endtask

   task automatic test_quarter();
`ifdef SVPWM_MINMAX_EN
      run_case(8192, 0, 1718, 781, 781, "quarter");
`else
      run_case(8192, 0, 1875, 937, 937, "quarter");
`endif
   endtask

   task automatic test_saturation();
      run_case(32767, 0, 2500, 0, 0, "sat");
      test_gate_window(2500, 0, 0, "sat");
   endtask

   task automatic test_random();
      int a, b, ea, eb, ec;
      for (int k = 0; k < 3; k++) begin
         a = int'($urandom_range(0, 131072)) - 65536;
         b = int'($urandom_range(0, 131072)) - 65536;
         ref_cmp(a, b, ea, eb, ec);
         run_case(a, b, ea, eb, ec, $sformatf("rand%0d", k));
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      int lat, tu1, tu2, ea, eb, ec;
      // A accepted, C while busy is dropped, B after A's done wins.
      wait_phase(200, ok);
      alpha = -19'sd20000; beta = -19'sd3000; start = 1'b1;
      @(negedge clk);
      alpha = 19'sd30000; beta = 19'sd30000;
      n_cmp++;
      if (busy !== 1'b1) begin
         n_bad++;
         $display("FAIL b2b_busy: got %b expected 1", busy);
      end
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 10 && !done; i++) @(negedge clk);
      n_cmp++;
      if (!ok || done !== 1'b1) begin
         n_bad++;
         $display("FAIL b2b_first_done: ok=%b done=%b expected 1", ok, done);
      end
      ref_cmp(5000, 20000, ea, eb, ec);
      run_case(5000, 20000, ea, eb, ec, "latest_wins");
      // D pending before the valley; E's done lands on the valley edge.
      wait_phase(300, ok);
      start_and_time(-8192, 12000, lat);
      n_cmp++;
      if (!ok || lat != 4) begin
         n_bad++;
         $display("FAIL b2b_d_latency: got %0d expected 4", lat);
      end
      wait_phase(CPER - 3, ok);
      start_and_time(16000, -5000, lat);
      tu1 = t_rst;
      ref_cmp(-8192, 12000, ea, eb, ec);
      n_cmp++;
      if (!ok || lat != 4 || update !== 1'b1 || (tu1 % CPER) != 1) begin
         n_bad++;
         $display("FAIL valley_coincide: lat=%0d update=%b phase=%0d expected 4/1/1", lat, update, tu1 % CPER);
      end
      n_cmp++;
      if (int'(cmp_a) != ea || int'(cmp_b) != eb || int'(cmp_c) != ec) begin
         n_bad++;
         $display("FAIL old_pending_used: got %0d/%0d/%0d expected %0d/%0d/%0d", cmp_a, cmp_b, cmp_c, ea, eb, ec);
      end
      wait_update(tu2);
      ref_cmp(16000, -5000, ea, eb, ec);
      n_cmp++;
      if (tu2 - tu1 != CPER) begin
         n_bad++;
         $display("FAIL deferred_load: got %0d cycles expected %0d", tu2 - tu1, CPER);
      end
      n_cmp++;
      if (int'(cmp_a) != ea || int'(cmp_b) != eb || int'(cmp_c) != ec) begin
         n_bad++;
         $display("FAIL deferred_values: got %0d/%0d/%0d expected %0d/%0d/%0d", cmp_a, cmp_b, cmp_c, ea, eb, ec);
      end
   endtask

   task automatic test_reset_midcompute();
      alpha = 19'sd8192; beta = 19'sd4000; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rstb = 1'b0;
      #1;
      n_cmp++;
      if ({busy, done, update, sync, pwm_a, pwm_b, pwm_c} !== 7'b0 || {cnt, cmp_a, cmp_b, cmp_c} !== 48'd0) begin
         n_bad++;
         $display("FAIL async_clear: flags=%b cnt=%0d cmp=%0d/%0d/%0d expected 0",
                  {busy, done, update, sync, pwm_a, pwm_b, pwm_c}, cnt, cmp_a, cmp_b, cmp_c);
      end
      repeat (2) @(negedge clk);
      rstb = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_cmp++;
         if (done !== 1'b0 || busy !== 1'b0 || int'(cnt) !== tri_cnt(t_rst)) begin
            n_bad++;
            $display("FAIL abort_no_done: done=%b busy=%b cnt=%0d expected 0/0/%0d", done, busy, cnt, tri_cnt(t_rst));
         end
      end
   endtask

   initial begin
      test_reset();
      test_carrier();
      test_zero();
      test_pwm_enable();
      test_quarter();
      test_saturation();
      test_random();
      test_back_to_back();
      test_reset_midcompute();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
